// File: rtl/mandel_line_scheduler.sv
// mandel_line_scheduler
//
// Hands the pixels of one Mandelbrot line to a bank of iteration engines
// and gathers their escape depths into the line result buffer.
//
// Pixels are issued in ascending x order, at most one per cycle, always to
// the lowest-indexed engine that is both ready and not already holding a
// pixel. Engine completions are held per engine and drained through one
// buffer write port with round-robin arbitration. When every pixel of the
// line has been written, line_done pulses for one cycle.
//
// Ports
//   out_stream_aclk  block clock
//   periph_resetn    synchronous active-low reset
//   line_start       starts a line (only honoured while idle)
//   line_y           row index, latched on an accepted line_start
//   busy             a line is in progress
//   line_done        one-cycle pulse after the last depth is written
//   eng_ready[i]     engine i is idle and can take a pixel
//   eng_start[i]     one-hot start pulse to engine i
//   eng_x, eng_y     pixel coordinates qualified by eng_start
//   eng_done[i]      engine i result valid (one-cycle pulse)
//   eng_depth        engine i depth on slice [i*DEPTH_W +: DEPTH_W]
//   res_we           result buffer write enable
//   res_addr         buffer address (pixel x)
//   res_depth        depth to write
module mandel_line_scheduler #(
    parameter int NUM_ENGINES = 4,
    parameter int X_SIZE      = 640,
    parameter int DEPTH_W     = 10,
    parameter int XW          = $clog2(X_SIZE)
) (
    input  logic                           out_stream_aclk,
    input  logic                           periph_resetn,
    input  logic                           line_start,
    input  logic [8:0]                     line_y,
    output logic                           busy,
    output logic                           line_done,
    input  logic [NUM_ENGINES-1:0]         eng_ready,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [XW-1:0]                  eng_x,
    output logic [8:0]                     eng_y,
    input  logic [NUM_ENGINES-1:0]         eng_done,
    input  logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth,
    output logic                           res_we,
    output logic [XW-1:0]                  res_addr,
    output logic [DEPTH_W-1:0]             res_depth
);

    localparam int          RRW   = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    localparam logic [XW:0] X_END = (XW+1)'(X_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic [XW:0]            next_x;
    logic [XW:0]            wr_cnt;
    logic [RRW-1:0]         rr_ptr;
    logic [NUM_ENGINES-1:0] assigned;
    logic [NUM_ENGINES-1:0] pending;
    logic [XW-1:0]          tag_x      [NUM_ENGINES];
    logic [DEPTH_W-1:0]     held_depth [NUM_ENGINES];

    logic [NUM_ENGINES-1:0] disp_onehot;
    logic                   disp_go;
    logic                   grant_found;
    logic [RRW-1:0]         grant_idx;
    logic                   grant_go;
    logic [NUM_ENGINES-1:0] grant_onehot;
    logic [RRW-1:0]         rr_next;
    logic [NUM_ENGINES-1:0] cap_mask;
    logic [NUM_ENGINES-1:0] assigned_nxt;
    logic [NUM_ENGINES-1:0] pending_nxt;

    // Lowest-indexed engine that is ready and not holding a pixel. The
    // descending scan leaves the lowest match as the final assignment.
    always_comb begin
        disp_onehot = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (eng_ready[i] && !assigned[i]) begin
                disp_onehot    = '0;
                disp_onehot[i] = 1'b1;
            end
        end
        disp_go = (state == RUN) && (next_x < X_END) && (disp_onehot != '0);
    end

    // Round-robin: first pending engine at or above rr_ptr; if none, wrap
    // to the lowest pending engine overall.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant_found = 1'b1;
                grant_idx   = RRW'(i);
            end
        end
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (pending[i] && (RRW'(i) >= rr_ptr)) begin
                grant_idx = RRW'(i);
            end
        end
        grant_go     = (state == RUN) && grant_found;
        grant_onehot = '0;
        if (grant_go) begin
            grant_onehot[grant_idx] = 1'b1;
        end
        rr_next = (grant_idx == RRW'(NUM_ENGINES - 1)) ? '0 : grant_idx + 1'b1;
    end

    // A completion only counts for an engine that owns a pixel and has not
    // already delivered it; anything else on eng_done is dropped. Capture
    // and grant never hit the same engine (one needs !pending, the other
    // pending), and dispatch never hits a granted engine (needs !assigned).
    always_comb begin
        cap_mask     = (state == RUN) ? (eng_done & assigned & ~pending) : '0;
        assigned_nxt = (assigned | (disp_go ? disp_onehot : '0)) & ~grant_onehot;
        pending_nxt  = (pending & ~grant_onehot) | cap_mask;
    end

    always_ff @(posedge out_stream_aclk) begin
        if (!periph_resetn) begin
            state     <= IDLE;
            busy      <= 1'b0;
            line_done <= 1'b0;
            eng_start <= '0;
            eng_x     <= '0;
            eng_y     <= '0;
            res_we    <= 1'b0;
            res_addr  <= '0;
            res_depth <= '0;
            next_x    <= '0;
            wr_cnt    <= '0;
            rr_ptr    <= '0;
            assigned  <= '0;
            pending   <= '0;
        end else begin
            line_done <= 1'b0;
            eng_start <= disp_go ? disp_onehot : '0;
            res_we    <= grant_go;
            assigned  <= assigned_nxt;
            pending   <= pending_nxt;

            case (state)
                IDLE: begin
                    if (line_start) begin
                        eng_y  <= line_y;
                        next_x <= '0;
                        wr_cnt <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (wr_cnt == X_END) begin
                        line_done <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            if (disp_go) begin
                eng_x  <= next_x[XW-1:0];
                next_x <= next_x + 1'b1;
            end

            if (grant_go) begin
                res_addr  <= tag_x[grant_idx];
                res_depth <= held_depth[grant_idx];
                rr_ptr    <= rr_next;
                wr_cnt    <= wr_cnt + 1'b1;
            end
        end
    end

    // Per-engine pixel tag and held depth are pure data: they are only read
    // while the matching assigned/pending flag is set, so they need no reset.
    always_ff @(posedge out_stream_aclk) begin
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (cap_mask[i]) begin
                held_depth[i] <= eng_depth[i*DEPTH_W +: DEPTH_W];
            end
            if (disp_go && disp_onehot[i]) begin
                tag_x[i] <= next_x[XW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_mandel_line_scheduler.sv
// Testbench for mandel_line_scheduler: behavioural engine array plus a
// line-level scoreboard (each x written once, correct depth, dispatch and
// line-end timing).
module tb_mandel_line_scheduler;

    localparam int NE = 4;
    localparam int XS = 640;
    localparam int DW = 10;
    localparam int XW = 10;

    localparam int F_FIRST = 1;
    localparam int F_SYNC  = 2;
    localparam int F_ABORT = 4;
    localparam int F_IGN   = 8;

    logic             clk = 1'b0;
    logic             periph_resetn;
    logic             line_start;
    logic [8:0]       line_y;
    logic             busy;
    logic             line_done;
    logic [NE-1:0]    eng_ready;
    logic [NE-1:0]    eng_start;
    logic [XW-1:0]    eng_x;
    logic [8:0]       eng_y;
    logic [NE-1:0]    eng_done;
    logic [NE*DW-1:0] eng_depth;
    logic             res_we;
    logic [XW-1:0]    res_addr;
    logic [DW-1:0]    res_depth;
    logic [45:0]      all_outs;

    assign all_outs = {busy, line_done, eng_start, eng_x, eng_y, res_we, res_addr, res_depth};

    mandel_line_scheduler #(
        .NUM_ENGINES(NE),
        .X_SIZE     (XS),
        .DEPTH_W    (DW),
        .XW         (XW)
    ) dut (
        .out_stream_aclk(clk),
        .periph_resetn  (periph_resetn),
        .line_start     (line_start),
        .line_y         (line_y),
        .busy           (busy),
        .line_done      (line_done),
        .eng_ready      (eng_ready),
        .eng_start      (eng_start),
        .eng_x          (eng_x),
        .eng_y          (eng_y),
        .eng_done       (eng_done),
        .eng_depth      (eng_depth),
        .res_we         (res_we),
        .res_addr       (res_addr),
        .res_depth      (res_depth)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // engine array controls (written by the main sequence only)
    logic [NE-1:0] ready_mask;
    int            lat_mode;
    int            lat_fixed;
    int            lat_lo;
    int            lat_hi;
    bit            depth_hash;
    bit            spur_on;

    // engine array state (written by the engine process only)
    logic [NE-1:0] eb;
    int            ecnt          [NE];
    int            ex            [NE];
    int            ey            [NE];
    int            last_done_cyc [NE];

    int n_assert = 0;
    int n_fail   = 0;
    int line_id  = 0;
    int seen_line [XS];
    int disp_line [XS];

    function automatic logic [DW-1:0] depth_of(input int x, input int y, input bit h);
        if (!h) return DW'(x % 1024);
        return DW'(((x * 5 + y * 3) ^ 341) % 1024);
    endfunction

    function automatic int lat_for(input int i);
        case (lat_mode)
            0:       return lat_fixed;
            1:       return 23 - i;
            default: return int'($urandom_range(lat_hi, lat_lo));
        endcase
    endfunction

    // Engine array: an engine started in cycle s with latency L pulses
    // eng_done in cycle s+L and is ready again from that same cycle.
    initial begin
        eng_ready = '0;
        eng_done  = '0;
        eng_depth = '0;
        eb        = '0;
        for (int i = 0; i < NE; i++) begin
            ecnt[i] = 0; ex[i] = 0; ey[i] = 0; last_done_cyc[i] = -100;
        end
        forever begin
            @(negedge clk);
            eng_done = '0;
            for (int i = 0; i < NE; i++) begin
                if (eb[i]) begin
                    if (ecnt[i] == 0) begin
                        eng_done[i] = 1'b1;
                        eng_depth[i*DW +: DW] = depth_of(ex[i], ey[i], depth_hash);
                        eb[i] = 1'b0;
                        last_done_cyc[i] = cyc;
                    end else begin
                        ecnt[i] = ecnt[i] - 1;
                    end
                end
            end
            if (spur_on && !eb[NE-1]) begin
                eng_done[NE-1] = 1'b1;
                eng_depth[(NE-1)*DW +: DW] = '1;
            end
            for (int i = 0; i < NE; i++) begin
                if (eng_start[i] === 1'b1) begin
                    eb[i]   = 1'b1;
                    ex[i]   = int'(eng_x);
                    ey[i]   = int'(eng_y);
                    ecnt[i] = lat_for(i) - 1;
                end
            end
            eng_ready = ready_mask & ~eb;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one line from line_start (driven in the current cycle) and
    // returns in cycle w+2 (DUT idle), or 40 cycles after a mid-line reset.
    task automatic run_line(input string tn, input logic [8:0] y, input int flags);
        int   c, k, nwr, nstart, ndone, dup, bad_d, bad_y, multi, bad_eng;
        int   gap_err, dup_disp, seq_err, first_start_cyc, first_x, last_we;
        int   done_cyc, r_cyc, ign_cyc, post_busy, budget, exp_cyc;
        logic [NE-1:0] first_oh;
        logic busy_c1, busy_after;
        bit   aborted, ign_done;
        nwr = 0; nstart = 0; ndone = 0; dup = 0; bad_d = 0; bad_y = 0; multi = 0;
        bad_eng = 0; gap_err = 0; dup_disp = 0; seq_err = 0; first_start_cyc = -1;
        first_x = -1; first_oh = '0; last_we = -1; done_cyc = -1; r_cyc = -1;
        ign_cyc = -10; post_busy = 0; budget = 0; aborted = 0; ign_done = 0;
        busy_c1 = 1'b0; busy_after = 1'b1;
        line_id++;
        line_start = 1'b1;
        line_y     = y;
        c          = cyc;
        forever begin
            @(negedge clk);
            #1;
            k = cyc;
            budget++;
            if (k == c + 1) begin
                line_start = 1'b0;
                line_y     = 9'($urandom);
                busy_c1    = busy;
            end
            if (eng_start != '0) begin
                nstart++;
                if (!$onehot(eng_start)) multi++;
                if ((eng_start & ~ready_mask) != '0) bad_eng++;
                if (eng_y !== y) bad_y++;
                if (int'(eng_x) >= XS || disp_line[eng_x] == line_id) dup_disp++;
                else disp_line[eng_x] = line_id;
                for (int i = 0; i < NE; i++)
                    if (eng_start[i] && (k - last_done_cyc[i]) < 3) gap_err++;
                if (first_start_cyc < 0) begin
                    first_start_cyc = k; first_oh = eng_start; first_x = int'(eng_x);
                end
            end
            if (res_we) begin
                if ((flags & F_SYNC) != 0) begin
                    exp_cyc = first_start_cyc + 25 + 26 * (nwr / 4) + (nwr % 4);
                    if (int'(res_addr) != nwr || k != exp_cyc) seq_err++;
                end
                nwr++;
                last_we = k;
                if (int'(res_addr) >= XS || seen_line[res_addr] == line_id) dup++;
                else seen_line[res_addr] = line_id;
                if (res_depth !== depth_of(int'(res_addr), int'(y), depth_hash)) bad_d++;
            end
            if (line_done) begin
                ndone++;
                done_cyc = k;
            end
            if ((flags & F_IGN) != 0) begin
                spur_on = (nwr >= 50 && nwr < 300);
                if (!ign_done && nwr >= 200) begin
                    line_start = 1'b1; line_y = 9'h1AA; ign_done = 1; ign_cyc = k;
                end else if (k == ign_cyc + 1) begin
                    line_start = 1'b0;
                end
            end
            if ((flags & F_ABORT) != 0) begin
                if (aborted && k > r_cyc && busy) post_busy++;
                if (!aborted && nwr >= 100) begin
                    periph_resetn = 1'b0; aborted = 1; r_cyc = k;
                end else if (aborted && k == r_cyc + 1) begin
                    periph_resetn = 1'b1;
                    check({tn, " outputs after reset"}, 64'(all_outs), 64'd0);
                end else if (aborted && k == r_cyc + 40) begin
                    break;
                end
            end
            if (done_cyc >= 0 && k == done_cyc + 1) begin
                busy_after = busy;
                break;
            end
            if (budget > 20000) break;
        end
        spur_on = 1'b0;
        check({tn, " busy at c+1"}, 64'(busy_c1), 64'd1);
        check({tn, " multi-hot eng_start"}, 64'(multi), 64'd0);
        check({tn, " start on unready engine"}, 64'(bad_eng), 64'd0);
        check({tn, " redispatch gap <3"}, 64'(gap_err), 64'd0);
        check({tn, " eng_y wrong"}, 64'(bad_y), 64'd0);
        check({tn, " duplicate dispatch x"}, 64'(dup_disp), 64'd0);
        check({tn, " duplicate/bad address"}, 64'(dup), 64'd0);
        check({tn, " depth errors"}, 64'(bad_d), 64'd0);
        if ((flags & F_ABORT) != 0) begin
            check({tn, " writes before reset"}, 64'(nwr), 64'd100);
            check({tn, " line_done on aborted line"}, 64'(ndone), 64'd0);
            check({tn, " busy after reset"}, 64'(post_busy), 64'd0);
        end else begin
            check({tn, " write count"}, 64'(nwr), 64'(XS));
            check({tn, " start count"}, 64'(nstart), 64'(XS));
            check({tn, " line_done count"}, 64'(ndone), 64'd1);
            check({tn, " line_done cycle"}, 64'(done_cyc), 64'(last_we + 1));
            check({tn, " busy at w+2"}, 64'(busy_after), 64'd0);
        end
        if ((flags & F_FIRST) != 0) begin
            check({tn, " first start cycle"}, 64'(first_start_cyc), 64'(c + 2));
            check({tn, " first start onehot"}, 64'(first_oh), 64'd1);
            check({tn, " first eng_x"}, 64'(first_x), 64'd0);
        end
        if ((flags & F_SYNC) != 0)
            check({tn, " grant order/timing"}, 64'(seq_err), 64'd0);
    endtask

    initial begin
        periph_resetn = 1'b0;
        line_start    = 1'b0;
        line_y        = '0;
        ready_mask    = '1;
        lat_mode      = 0;
        lat_fixed     = 20;
        lat_lo        = 1;
        lat_hi        = 1;
        depth_hash    = 1'b0;
        spur_on       = 1'b0;
        for (int i = 0; i < XS; i++) begin
            seen_line[i] = 0;
            disp_line[i] = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        check("reset outputs", 64'(all_outs), 64'd0);
        periph_resetn = 1'b1;
        @(negedge clk);
        #1;

        // all four engines finish together every batch
        lat_mode = 1; depth_hash = 1'b1; ready_mask = 4'b1111;
        run_line("sync", 9'd3, F_SYNC | F_FIRST);

        // fixed latency 20, depth = x
        lat_mode = 0; lat_fixed = 20; depth_hash = 1'b0;
        run_line("fixed", 9'd0, F_FIRST);

        // only engine 2 ever ready
        lat_mode = 2; lat_lo = 1; lat_hi = 6; depth_hash = 1'b1; ready_mask = 4'b0100;
        run_line("single", 9'd100, 0);

        // stray line_start in RUN and spurious eng_done on never-used engine 3
        lat_lo = 1; lat_hi = 10; ready_mask = 4'b0011;
        run_line("ignored", 9'd200, F_IGN);

        // reset after 100 writes, then a full line
        lat_lo = 5; lat_hi = 30; ready_mask = 4'b1111;
        run_line("abort", 9'd50, F_ABORT);
        run_line("after-abort", 9'd77, 0);

        // back-to-back rows, second start issued in w+2
        lat_lo = 1; lat_hi = 20;
        run_line("b2b y5", 9'd5, 0);
        run_line("b2b y6", 9'd6, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mandel_line_scheduler.md
# mandel_line_scheduler

Dispatches the pixels of one Mandelbrot line across `NUM_ENGINES` iteration engines and collects their escape depths into the line result buffer. It sits between the line-level start/done control and the engine array. It issues at most one pixel per cycle to the lowest-indexed free engine, and serialises simultaneous completions into a single buffer write port with round-robin arbitration. It pulses `line_done` once all `X_SIZE` depths are written.

## Interface
- `NUM_ENGINES`, 4: number of iteration engines; valid range 1..8.
- `X_SIZE`, 640: pixels per line.
- `DEPTH_W`, 10: width of an escape depth.
- `XW`, `$clog2(X_SIZE)`: width of an x coordinate.

- `out_stream_aclk` in 1: the single clock for the block.
- `periph_resetn` in 1: synchronous, active-low reset.
- `line_start` in 1: pulse that starts a line; sampled only in IDLE.
- `line_y` in 9: row index; latched when `line_start` is accepted.
- `busy` out 1: a line is in progress.
- `line_done` out 1: one-cycle pulse after the last depth is written.
- `eng_ready` in NUM_ENGINES: engine i is idle and can accept a pixel.
- `eng_start` out NUM_ENGINES: one-hot start pulse; at most one bit high per cycle.
- `eng_x` out XW: x coordinate qualified by `eng_start`.
- `eng_y` out 9: latched `line_y`.
- `eng_done` in NUM_ENGINES: engine i result valid; one-cycle pulse.
- `eng_depth` in NUM_ENGINES*DEPTH_W: engine i depth on slice `[i*DEPTH_W +: DEPTH_W]`.
- `res_we` out 1: result buffer write enable.
- `res_addr` out XW: buffer address, which is the pixel x.
- `res_depth` out DEPTH_W: depth to write.

## Operation
- **States:**
  - IDLE: on `line_start`, latch `line_y`, clear `next_x` and `wr_cnt`, go to RUN.
  - RUN: go to DONE when `wr_cnt == X_SIZE`.
  - DONE: lasts one cycle, pulses `line_done`, returns to IDLE.
- **Per-engine state:** `assigned[i]`, `tag_x[i]` (XW bits), `pending[i]`, `held_depth[i]`.
- **Dispatch** (RUN, each cycle):
  - Condition: `next_x < X_SIZE`.
  - Pick the lowest i with `eng_ready[i] & !assigned[i]`.
  - Register `eng_start[i]=1` and `eng_x=next_x`.
  - Set `assigned[i]` and `tag_x[i]=next_x`, then increment `next_x`.
  - No dispatch once `next_x == X_SIZE`.
- **Capture:**
  - `eng_done[i] & assigned[i] & !pending[i]` sets `pending[i]` and latches the slice into `held_depth[i]`.
  - `eng_done` on an unassigned or already-pending engine is ignored.
- **Write arbitration:**
  - Round-robin over `pending`, starting at `rr_ptr`. One grant per cycle.
  - Grant k registers `res_we=1`, `res_addr=tag_x[k]`, `res_depth=held_depth[k]`.
  - On the same edge: clear `pending[k]` and `assigned[k]`, set `rr_ptr=(k+1) mod NUM_ENGINES`, increment `wr_cnt`.
- **Same-cycle events:** capture on engine j and grant on engine k≠j in the same cycle are both honoured. Dispatch and grant in the same cycle are both honoured.
- **Ignored inputs:** `line_start` in RUN or DONE is ignored.
- **Reset** (any time, including mid-line):
  - IDLE, all flags clear, `next_x=0`, `wr_cnt=0`, `rr_ptr=0`.
  - No `line_done` is issued for the aborted line.
- **Widths:**
  - `next_x` and `wr_cnt` are XW+1 bits, so they can hold `X_SIZE`.
  - All compares are unsigned.

## Timing
- **Output reset values:** all 0. That covers `busy`, `line_done`, `eng_start`, `eng_x`, `eng_y`, `res_we`, `res_addr` and `res_depth`.
- **Registered outputs:** every output is registered; no combinational input-to-output paths.
- **Dispatch latency:** `line_start` high in cycle c → `busy` high from c+1 → earliest `eng_start` in c+2.
- **Dispatch rate:** one `eng_start` per cycle maximum.
- **Write latency:** `eng_done[i]` in cycle d → earliest `res_we` for that pixel in d+2.
- **Re-dispatch:** engine i is re-eligible in d+2, so its next `eng_start` is earliest in d+3.
- **Write rate:** one `res_we` per cycle maximum.
- **Line end:** last `res_we` in cycle w → `line_done` high in w+1 for exactly one cycle → `busy` low from w+2.
- **Next line:** `line_start` is accepted again from w+2.
- **Ordering:** `res_addr` order is unspecified. Each x in 0..X_SIZE-1 is written exactly once per line.

## Test plan
- **Fixed latency, all engines:**
  - Stub: 4 engines, fixed latency 20, depth = x mod 1024, `line_start` once.
  - Expect: 640 `res_we`, each `res_depth == res_addr`, no duplicate addresses.
  - Expect: first `eng_start` one-hot 0001 with `eng_x=0`, 2 cycles after `line_start`.
  - Expect: exactly one `line_done`, 1 cycle after the last write.
- **Simultaneous completion:**
  - Stub: all 4 engines raise `eng_done` in the same cycle d.
  - Expect: `res_we` in d+2..d+5, granted in order 0,1,2,3 from `rr_ptr=0`, then `rr_ptr` back to 0.
  - Expect: no depth lost, each address matching its `tag_x`.
- **Single engine ready:**
  - Stub: only engine 2 ever asserts `eng_ready`.
  - Expect: all 640 pixels go to engine 2.
  - Expect: next `eng_start[2]` ≥ 3 cycles after each `eng_done[2]`.
- **Reset mid-line:**
  - Stimulus: `periph_resetn` low for one cycle after 100 writes.
  - Expect: all outputs 0 the next cycle, no `line_done`.
  - Expect: a new `line_start` completes 640 writes.
- **Ignored inputs:**
  - Stimulus: `line_start` pulsed during RUN; spurious `eng_done` on an idle engine.
  - Expect: no effect, `wr_cnt` unchanged, still exactly 640 writes.
- **Back-to-back lines:**
  - Stimulus: `line_start` in w+2 after `line_done`, with `line_y=5` then 6.
  - Expect: `eng_y` follows the latched row; `busy` low for exactly one cycle between lines.
